// File: rtl/debug_pkg.sv
// Shared debug definitions: run-control state encoding and the
// debugger opcode values also used by the existing debug controller.
package debug_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HALT_WAIT  = 2'd1,
        HALTED     = 2'd2,
        RESET_HOLD = 2'd3
    } dbg_state_e;

    localparam logic [7:0] HALT   = 8'h01;
    localparam logic [7:0] RESUME = 8'h02;
    localparam logic [7:0] RESET  = 8'h03;

endpackage

// File: rtl/debug_run_control.sv
// Debug run control: halts, resumes and resets the CPU on debugger request,
// and gates debugger memory writes to the time the CPU is halted.
// Ports: cpu_clk/cpu_rstn (clock, async active-low reset); op_valid/op_code
// (debugger command); cpu_at_boundary (safe-to-freeze); dbg_*_we_in (raw
// write strobes) -> cpu_stall, cpu_reset_req, dbg_mem_grant, *_we_out,
// halt_forced, drop_count, state.
module debug_run_control
    import debug_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned HALT_TIMEOUT = 256
) (
    input  logic       cpu_clk,
    input  logic       cpu_rstn,
    input  logic       op_valid,
    input  logic [7:0] op_code,
    input  logic       cpu_at_boundary,
    input  logic       dbg_imem_we_in,
    input  logic       dbg_dmem_we_in,
    output logic       cpu_stall,
    output logic       cpu_reset_req,
    output logic       dbg_mem_grant,
    output logic       imem_we_out,
    output logic       dmem_we_out,
    output logic       halt_forced,
    output logic [7:0] drop_count,
    output logic [1:0] state
);

    // The shared counter counts down to zero; loading N-1 gives N cycles.
    localparam logic [15:0] RST_LOAD = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] TO_LOAD  = 16'(HALT_TIMEOUT - 1);

    dbg_state_e  state_q, state_d;
    dbg_state_e  ret_q, ret_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hf_q, hf_d;
    logic [7:0]  drop_q, drop_d;
    logic        imem_we_q, dmem_we_q;

    logic        is_halt, is_resume, is_reset;
    logic        grant;
    logic        ref_i, ref_d;
    logic [8:0]  drop_sum;

    assign is_halt   = op_valid && (op_code == HALT);
    assign is_resume = op_valid && (op_code == RESUME);
    assign is_reset  = op_valid && (op_code == RESET);

    assign grant = (state_q == HALTED);

    // Priority: RESET > RESUME > boundary > timeout.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        hf_d    = hf_q;
        unique case (state_q)
            RUN: begin
                if (is_reset) begin
                    state_d = RESET_HOLD;
                    ret_d   = RUN;
                    cnt_d   = RST_LOAD;
                end else if (is_halt) begin
                    state_d = HALT_WAIT;
                    cnt_d   = TO_LOAD;
                end
            end
            HALT_WAIT: begin
                if (is_reset) begin
                    state_d = RESET_HOLD;
                    ret_d   = HALTED;
                    cnt_d   = RST_LOAD;
                end else if (is_resume) begin
                    state_d = RUN;
                end else if (cpu_at_boundary) begin
                    state_d = HALTED;
                    hf_d    = 1'b0;
                end else if (cnt_q == 16'd0) begin
                    state_d = HALTED;
                    hf_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HALTED: begin
                if (is_reset) begin
                    state_d = RESET_HOLD;
                    ret_d   = HALTED;
                    cnt_d   = RST_LOAD;
                end else if (is_resume) begin
                    state_d = RUN;
                    hf_d    = 1'b0;
                end
            end
            RESET_HOLD: begin
                if (cnt_q == 16'd0) begin
                    state_d = ret_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Refused strobes add 0, 1 or 2; the 9-bit sum detects saturation.
    assign ref_i    = dbg_imem_we_in & ~grant;
    assign ref_d    = dbg_dmem_we_in & ~grant;
    assign drop_sum = {1'b0, drop_q} + {8'd0, ref_i} + {8'd0, ref_d};
    assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q   <= RUN;
            ret_q     <= RUN;
            cnt_q     <= 16'd0;
            hf_q      <= 1'b0;
            drop_q    <= 8'd0;
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cnt_q     <= cnt_d;
            hf_q      <= hf_d;
            drop_q    <= drop_d;
            imem_we_q <= dbg_imem_we_in & grant;
            dmem_we_q <= dbg_dmem_we_in & grant;
        end
    end

    assign cpu_stall     = (state_q == HALTED) || (state_q == RESET_HOLD);
    assign cpu_reset_req = (state_q == RESET_HOLD);
    assign dbg_mem_grant = grant;
    assign imem_we_out   = imem_we_q;
    assign dmem_we_out   = dmem_we_q;
    assign halt_forced   = hf_q;
    assign drop_count    = drop_q;
    assign state         = state_q;

endmodule
